// File: rtl/mem_port_arbiter.sv
// Three-way arbiter sharing one memory port between fetch, load and store requesters.
// Fixed priority store > load > fetch by default; define MEM_ARB_RR_EN for round-robin.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_if_req,
    input  logic [ADDR_W-1:0] i_if_addr,
    output logic [DATA_W-1:0] o_if_data,
    output logic              o_if_ack,
    input  logic              i_rd_req,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_rd_ack,
    input  logic              i_wr_req,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic              o_wr_ack,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    input  logic              i_mem_ack,
    output logic [1:0]        o_grant
);

    localparam logic [1:0] GNT_NONE = 2'd0;
    localparam logic [1:0] GNT_IF   = 2'd1;
    localparam logic [1:0] GNT_RD   = 2'd2;
    localparam logic [1:0] GNT_WR   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic              r_mem_req,   w_mem_req_next;
    logic              r_mem_we,    w_mem_we_next;
    logic [ADDR_W-1:0] r_mem_addr,  w_mem_addr_next;
    logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata_next;
    logic [1:0]        r_grant,     w_grant_next;
    logic              r_if_ack,    w_if_ack_next;
    logic              r_rd_ack,    w_rd_ack_next;
    logic              r_wr_ack,    w_wr_ack_next;
    logic [DATA_W-1:0] r_if_data,   w_if_data_next;
    logic [DATA_W-1:0] r_rd_data,   w_rd_data_next;
    logic [1:0]        w_win;

`ifdef MEM_ARB_RR_EN
    // Pointer names the port searched first: 0 fetch, 1 load, 2 store.
    logic [1:0] r_rr_ptr;
    logic [1:0] w_rr_ptr_next;

    always_comb begin
        w_win = GNT_NONE;
        case (r_rr_ptr)
            2'd1:    w_win = i_rd_req ? GNT_RD : i_wr_req ? GNT_WR : i_if_req ? GNT_IF : GNT_NONE;
            2'd2:    w_win = i_wr_req ? GNT_WR : i_if_req ? GNT_IF : i_rd_req ? GNT_RD : GNT_NONE;
            default: w_win = i_if_req ? GNT_IF : i_rd_req ? GNT_RD : i_wr_req ? GNT_WR : GNT_NONE;
        endcase
    end

    // Grant code of the winner equals the pointer value of the port after it, except store.
    always_comb begin
        w_rr_ptr_next = r_rr_ptr;
        if (r_state == ST_IDLE && w_win != GNT_NONE)
            w_rr_ptr_next = (w_win == GNT_WR) ? 2'd0 : w_win;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            r_rr_ptr <= 2'd0;
        else
            r_rr_ptr <= w_rr_ptr_next;
    end
`else
    assign w_win = i_wr_req ? GNT_WR : i_rd_req ? GNT_RD : i_if_req ? GNT_IF : GNT_NONE;
`endif

    always_comb begin
        w_state_next     = r_state;
        w_mem_req_next   = r_mem_req;
        w_mem_we_next    = r_mem_we;
        w_mem_addr_next  = r_mem_addr;
        w_mem_wdata_next = r_mem_wdata;
        w_grant_next     = r_grant;
        w_if_ack_next    = 1'b0;
        w_rd_ack_next    = 1'b0;
        w_wr_ack_next    = 1'b0;
        w_if_data_next   = r_if_data;
        w_rd_data_next   = r_rd_data;

        case (r_state)
            ST_IDLE: begin
                if (w_win != GNT_NONE) begin
                    w_state_next   = ST_BUSY;
                    w_mem_req_next = 1'b1;
                    w_grant_next   = w_win;
                    case (w_win)
                        GNT_WR: begin
                            w_mem_we_next    = 1'b1;
                            w_mem_addr_next  = i_wr_addr;
                            w_mem_wdata_next = i_wr_data;
                        end
                        GNT_RD: begin
                            w_mem_we_next    = 1'b0;
                            w_mem_addr_next  = i_rd_addr;
                            w_mem_wdata_next = '0;
                        end
                        default: begin
                            w_mem_we_next    = 1'b0;
                            w_mem_addr_next  = i_if_addr;
                            w_mem_wdata_next = '0;
                        end
                    endcase
                end
            end
            ST_BUSY: begin
                // Requester req is not re-checked here: a dropped req still gets its ack.
                if (i_mem_ack) begin
                    w_state_next     = ST_DONE;
                    w_mem_req_next   = 1'b0;
                    w_mem_we_next    = 1'b0;
                    w_mem_addr_next  = '0;
                    w_mem_wdata_next = '0;
                    w_grant_next     = GNT_NONE;
                    case (r_grant)
                        GNT_IF: begin
                            w_if_ack_next  = 1'b1;
                            w_if_data_next = i_mem_rdata;
                        end
                        GNT_RD: begin
                            w_rd_ack_next  = 1'b1;
                            w_rd_data_next = i_mem_rdata;
                        end
                        GNT_WR:  w_wr_ack_next = 1'b1;
                        default: ;
                    endcase
                end
            end
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_grant     <= GNT_NONE;
            r_if_ack    <= 1'b0;
            r_rd_ack    <= 1'b0;
            r_wr_ack    <= 1'b0;
            r_if_data   <= '0;
            r_rd_data   <= '0;
        end else begin
            r_state     <= w_state_next;
            r_mem_req   <= w_mem_req_next;
            r_mem_we    <= w_mem_we_next;
            r_mem_addr  <= w_mem_addr_next;
            r_mem_wdata <= w_mem_wdata_next;
            r_grant     <= w_grant_next;
            r_if_ack    <= w_if_ack_next;
            r_rd_ack    <= w_rd_ack_next;
            r_wr_ack    <= w_wr_ack_next;
            r_if_data   <= w_if_data_next;
            r_rd_data   <= w_rd_data_next;
        end
    end

    assign o_mem_req   = r_mem_req;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_grant     = r_grant;
    assign o_if_ack    = r_if_ack;
    assign o_rd_ack    = r_rd_ack;
    assign o_wr_ack    = r_wr_ack;
    assign o_if_data   = r_if_data;
    assign o_rd_data   = r_rd_data;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level model checked every cycle plus directed
// literal expectations; honours MEM_ARB_RR_EN the same way as the design.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, rd_req, wr_req;
    logic [31:0] if_addr, rd_addr, wr_addr, wr_data;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic [31:0] if_data, rd_data, mem_addr, mem_wdata;
    logic        if_ack, rd_ack, wr_ack, mem_req, mem_we;
    logic [1:0]  grant;

    int checks = 0;
    int errors = 0;
    bit check_en = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .i_clk(clk), .i_reset(rst),
        .i_if_req(if_req), .i_if_addr(if_addr), .o_if_data(if_data), .o_if_ack(if_ack),
        .i_rd_req(rd_req), .i_rd_addr(rd_addr), .o_rd_data(rd_data), .o_rd_ack(rd_ack),
        .i_wr_req(wr_req), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .o_wr_ack(wr_ack),
        .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata), .i_mem_ack(mem_ack),
        .o_grant(grant)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    function automatic logic [31:0] rdata_of(input logic [31:0] a);
        return (a == 32'h100) ? 32'hDEADBEEF : (a ^ 32'h5A5A_0000);
    endfunction

    // ---------------- memory responder ----------------
    int          mem_lat  = 0;
    bit          mem_auto = 1;
    bit          stray_go = 0;
    logic [31:0] log_addr[$];
    logic [31:0] log_wdata[$];
    logic        log_we[$];
    logic [1:0]  log_gnt[$];

    initial begin
        int cnt;
        cnt       = 0;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (rst) begin
                cnt     = 0;
                mem_ack = 1'b0;
            end else if (!mem_auto) begin
                mem_ack = stray_go;
                if (stray_go) mem_rdata = 32'hFFFF_FFFF;
            end else if (mem_ack) begin
                mem_ack = 1'b0;
                cnt     = 0;
            end else if (mem_req) begin
                if (cnt >= mem_lat) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rdata_of(mem_addr);
                    log_addr.push_back(mem_addr);
                    log_wdata.push_back(mem_wdata);
                    log_we.push_back(mem_we);
                    log_gnt.push_back(grant);
                    $display("txn %0d: grant=%0d we=%0d addr=%h wdata=%h", log_addr.size(),
                             grant, mem_we, mem_addr, mem_wdata);
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // ---------------- behavioural model ----------------
    // Transaction view: a port owns the memory from grant until its ack cycle has passed.
    int          m_owner = 0;
    bit          m_ack_cycle = 0;
    int          m_ptr = 0;
    logic        e_mem_req = 0, e_mem_we = 0;
    logic [31:0] e_mem_addr = 0, e_mem_wdata = 0;
    logic [1:0]  e_grant = 0;
    logic        e_if_ack = 0, e_rd_ack = 0, e_wr_ack = 0;
    logic [31:0] e_if_data = 0, e_rd_data = 0;

    function automatic bit req_of(input int port);
        return (port == 1) ? if_req : (port == 2) ? rd_req : wr_req;
    endfunction

    function automatic int pick();
        int w;
        w = 0;
`ifdef MEM_ARB_RR_EN
        for (int k = 0; k < 3; k++) begin
            int p;
            p = (m_ptr + k) % 3;
            if (w == 0 && req_of(p + 1)) begin
                w     = p + 1;
                m_ptr = (p + 1) % 3;
            end
        end
`else
        for (int port = 3; port >= 1; port--)
            if (w == 0 && req_of(port)) w = port;
`endif
        return w;
    endfunction

    task automatic model_step();
        int w;
        if (rst) begin
            m_owner = 0; m_ack_cycle = 0; m_ptr = 0;
            e_mem_req = 0; e_mem_we = 0; e_mem_addr = 0; e_mem_wdata = 0; e_grant = 0;
            e_if_ack = 0; e_rd_ack = 0; e_wr_ack = 0; e_if_data = 0; e_rd_data = 0;
        end else begin
            e_if_ack = 0; e_rd_ack = 0; e_wr_ack = 0;
            if (m_ack_cycle) begin
                m_ack_cycle = 0;
            end else if (m_owner != 0) begin
                if (mem_ack) begin
                    if (m_owner == 1) begin e_if_ack = 1; e_if_data = mem_rdata; end
                    if (m_owner == 2) begin e_rd_ack = 1; e_rd_data = mem_rdata; end
                    if (m_owner == 3) e_wr_ack = 1;
                    e_mem_req = 0; e_mem_we = 0; e_mem_addr = 0; e_mem_wdata = 0; e_grant = 0;
                    m_owner = 0;
                    m_ack_cycle = 1;
                end
            end else begin
                w = pick();
                if (w != 0) begin
                    m_owner     = w;
                    e_mem_req   = 1;
                    e_grant     = 2'(w);
                    e_mem_we    = (w == 3);
                    e_mem_addr  = (w == 1) ? if_addr : (w == 2) ? rd_addr : wr_addr;
                    e_mem_wdata = (w == 3) ? wr_data : 32'h0;
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        model_step();
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge clk);
        if (!rst && check_en) begin
            chk("cyc_mem_req",   mem_req,   e_mem_req);
            chk("cyc_mem_we",    mem_we,    e_mem_we);
            chk("cyc_mem_addr",  mem_addr,  e_mem_addr);
            chk("cyc_mem_wdata", mem_wdata, e_mem_wdata);
            chk("cyc_grant",     grant,     e_grant);
            chk("cyc_if_ack",    if_ack,    e_if_ack);
            chk("cyc_rd_ack",    rd_ack,    e_rd_ack);
            chk("cyc_wr_ack",    wr_ack,    e_wr_ack);
            chk("cyc_if_data",   if_data,   e_if_data);
            chk("cyc_rd_data",   rd_data,   e_rd_data);
        end
    end

    // ---------------- requester ----------------
    function automatic bit ack_of(input int port);
        return (port == 1) ? if_ack : (port == 2) ? rd_ack : wr_ack;
    endfunction

    // Called just after a falling edge; returns how many cycles until the ack was seen.
    task automatic run_req(input int port, input logic [31:0] a, input logic [31:0] d,
                           output int lat);
        case (port)
            1: begin if_addr = a; if_req = 1'b1; end
            2: begin rd_addr = a; rd_req = 1'b1; end
            default: begin wr_addr = a; wr_data = d; wr_req = 1'b1; end
        endcase
        lat = -1;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (ack_of(port)) begin
                lat = n;
                break;
            end
        end
        case (port)
            1: if_req = 1'b0;
            2: rd_req = 1'b0;
            default: wr_req = 1'b0;
        endcase
        if (lat < 0) timeout($sformatf("req_port%0d", port));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int lat1, lat2, lat3, base;
        logic [1:0]  exp_gnt[6];
        logic [31:0] exp_c[3];
        rst = 1'b1;
        if_req = 0; rd_req = 0; wr_req = 0;
        if_addr = 0; rd_addr = 0; wr_addr = 0; wr_data = 0;

        repeat (3) @(negedge clk);
        chk("reset_mem_req", mem_req, 0);
        chk("reset_grant", grant, 0);
        chk("reset_acks", {if_ack, rd_ack, wr_ack}, 0);
        chk("reset_mem_addr", mem_addr, 0);
        rst = 1'b0;
        check_en = 1;

        // Single fetch, memory waits two cycles.
        mem_lat = 2;
        @(negedge clk);
        run_req(1, 32'h100, 32'h0, lat1);
        chk("t1_latency", lat1, 4);
        chk("t1_if_data", if_data, 32'hDEADBEEF);
        chk("t1_grant_done", grant, 0);
        chk("t1_mem_addr", log_addr[log_addr.size()-1], 32'h100);
        chk("t1_mem_we", log_we[log_we.size()-1], 0);

        // Store.
        mem_lat = 1;
        @(negedge clk);
        run_req(3, 32'h40, 32'h1234_5678, lat1);
        chk("t3_latency", lat1, 3);
        chk("t3_mem_we", log_we[log_we.size()-1], 1);
        chk("t3_mem_wdata", log_wdata[log_wdata.size()-1], 32'h1234_5678);
        chk("t3_if_data_kept", if_data, 32'hDEADBEEF);
        chk("t3_rd_data_kept", rd_data, 0);
        @(negedge clk);
        chk("t3_wr_ack_one_cycle", wr_ack, 0);

        // Stray memory ack while idle.
        mem_auto = 0;
        @(posedge clk); #1 stray_go = 1;
        @(posedge clk); #1 stray_go = 0;
        chk("t6_no_ack", {if_ack, rd_ack, wr_ack}, 0);
        chk("t6_if_data", if_data, 32'hDEADBEEF);
        chk("t6_rd_data", rd_data, 0);
        chk("t6_mem_req", mem_req, 0);
        @(negedge clk);
        mem_auto = 1;

        // Contention: all three raised together, each dropped after its own ack.
        mem_lat = 0;
        @(negedge clk);
        base = log_addr.size();
        fork
            run_req(1, 32'h104, 32'h0, lat1);
            run_req(2, 32'h204, 32'h0, lat2);
            run_req(3, 32'h304, 32'hCAFE_0001, lat3);
        join
`ifdef MEM_ARB_RR_EN
        exp_c[0] = 32'h104; exp_c[1] = 32'h204; exp_c[2] = 32'h304;
`else
        exp_c[0] = 32'h304; exp_c[1] = 32'h204; exp_c[2] = 32'h104;
`endif
        if (log_addr.size() < base + 3) timeout("t2_txn_count");
        else for (int i = 0; i < 3; i++)
            chk($sformatf("t2_order%0d", i), log_addr[base+i], exp_c[i]);
        chk("t2_rd_data", rd_data, 32'h5A5A_0204);
        chk("t2_if_data", if_data, 32'h5A5A_0104);

        // All three held continuously for six transactions.
`ifdef MEM_ARB_RR_EN
        exp_gnt = '{2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd3};
`else
        exp_gnt = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
`endif
        @(negedge clk);
        base = log_gnt.size();
        if_addr = 32'h100; rd_addr = 32'h200; wr_addr = 32'h300; wr_data = 32'h0BAD_F00D;
        if_req = 1; rd_req = 1; wr_req = 1;
        for (int n = 0; n < 300 && log_gnt.size() < base + 6; n++) @(negedge clk);
        if_req = 0; rd_req = 0; wr_req = 0;
        repeat (3) @(negedge clk);
        if (log_gnt.size() != base + 6) timeout("t4_txn_count");
        else for (int i = 0; i < 6; i++)
            chk($sformatf("t4_grant%0d", i), log_gnt[base+i], exp_gnt[i]);

        // Reset while the memory is still busy.
        mem_lat = 20;
        @(negedge clk);
        wr_addr = 32'h80; wr_data = 32'h1; wr_req = 1;
        for (int n = 0; n < 20 && !mem_req; n++) @(negedge clk);
        chk("t5_busy_before_reset", mem_req, 1);
        #1 rst = 1'b1;
        #1;
        chk("t5_mem_req", mem_req, 0);
        chk("t5_grant", grant, 0);
        chk("t5_acks", {if_ack, rd_ack, wr_ack}, 0);
        chk("t5_data", {if_data, rd_data}, 0);
        wr_req = 0;
        @(negedge clk);
        rst = 1'b0;
        mem_lat = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            chk("t5_no_spurious_ack", {if_ack, rd_ack, wr_ack, mem_req}, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
